// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle mini CPU: opcodes, ALU op encodings,
// sequencer states and the decoded-instruction bundle.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Encodings understood by the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } seq_state_e;

  typedef struct packed {
    logic       is_alu;
    logic       is_load;
    logic       is_store;
    logic       is_jmp;
    logic       is_jz;
    logic       is_halt;
    logic       illegal;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer and memories.
interface cpu_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 12
) ();
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] instr;
  logic               dmem_req;
  logic               dmem_we;
  logic [ADDR_W-1:0]  dmem_addr;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
    input  imem_ack, instr, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
    output imem_ack, instr, dmem_ack
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier; undefined opcodes are flagged illegal and
// otherwise behave as NOP.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output dec_t             dec
);

  logic [3:0] op;
  assign op = 4'(opc);

  always_comb begin
    dec = '0;
    case (op)
      OP_NOP:   ;
      OP_LOAD:  dec.is_load  = 1'b1;
      OP_STORE: dec.is_store = 1'b1;
      OP_ADD:   begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB:   begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND:   begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:    begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_XOR:   begin dec.is_alu = 1'b1; dec.alu_op = ALU_XOR; end
      OP_JMP:   dec.is_jmp  = 1'b1;
      OP_JZ:    dec.is_jz   = 1'b1;
      OP_HALT:  dec.is_halt = 1'b1;
      default:  dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/memory control FSM for the mini CPU: owns PC, IR,
// zero flag and a bus watchdog that halts the core on a missing acknowledge.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int RSEL_W   = 2,
  parameter int ADDR_W   = 6,
  parameter int WAIT_MAX = 15,
  localparam int INSTR_W = OPC_W + RSEL_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  cpu_sequencer_if.master   bus,
  output logic              reg_write,
  output logic [RSEL_W-1:0] reg_sel,
  output logic [2:0]        alu_op,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              bus_err,
  output logic              illegal
);

  localparam int WD_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  seq_state_e         state;
  logic [INSTR_W-1:0] ir;
  logic               z;
  logic [WD_W-1:0]    wd_cnt;
  dec_t               dec;

  logic [OPC_W-1:0]  ir_opc;
  logic [RSEL_W-1:0] ir_rsel;
  logic [ADDR_W-1:0] ir_addr;
  assign ir_opc  = ir[INSTR_W-1 -: OPC_W];
  assign ir_rsel = ir[ADDR_W +: RSEL_W];
  assign ir_addr = ir[ADDR_W-1:0];

  cpu_ctrl_decode #(.OPC_W(OPC_W)) u_dec (.opc(ir_opc), .dec(dec));

  logic mem_ack, wd_expire;
  assign mem_ack   = (state == S_FETCH) ? bus.imem_ack : bus.dmem_ack;
  // Expiry is judged on the count before this cycle, so an ack in the
  // WAIT_MAX-th waiting cycle still completes the access.
  assign wd_expire = (WAIT_MAX != 0) && (int'(wd_cnt) == WAIT_MAX - 1);

  assign bus.imem_req  = (state == S_FETCH);
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = (state == S_MEM);
  assign bus.dmem_we   = (state == S_MEM) && dec.is_store;
  assign bus.dmem_addr = ir_addr;

  // LOAD write strobe is the one Mealy output: the datapath captures read
  // data on the same edge the ack is sampled.
  assign reg_write = ((state == S_EXEC) && dec.is_alu) ||
                     ((state == S_MEM) && dec.is_load && bus.dmem_ack);
  assign reg_sel   = (state == S_MEM) ? ir_rsel : '0;
  assign alu_op    = ((state == S_EXEC) && dec.is_alu) ? dec.alu_op : ALU_ADD;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      z       <= 1'b0;
      wd_cnt  <= '0;
      bus_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (mem_ack) begin
            wd_cnt <= '0;
            if (state == S_FETCH) begin
              ir    <= bus.instr;
              state <= S_DECODE;
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= S_FETCH;
            end
          end else if (wd_expire) begin
            wd_cnt  <= '0;
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else if (WAIT_MAX != 0) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_DECODE: begin
          if (dec.is_load || dec.is_store) state <= S_MEM;
          else if (dec.is_halt)            state <= S_HALT;
          else                             state <= S_EXEC;
        end
        S_EXEC: begin
          if (dec.is_alu)  z       <= alu_zero;
          if (dec.illegal) illegal <= 1'b1;
          if (dec.is_jmp || (dec.is_jz && z)) pc <= ir_addr;
          else                                pc <= pc + ADDR_W'(1);
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs in a behavioural
// instruction ROM, wait-state responders, and a negedge monitor.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int OPC_W = 4, RSEL_W = 2, ADDR_W = 6, INSTR_W = 12;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, alu_zero = 1'b0;
  logic              reg_write;
  logic [RSEL_W-1:0] reg_sel;
  logic [2:0]        alu_op;
  logic [ADDR_W-1:0] pc;
  logic              halted, bus_err, illegal;

  cpu_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  cpu_sequencer #(.OPC_W(OPC_W), .RSEL_W(RSEL_W), .ADDR_W(ADDR_W), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .reg_write(reg_write), .reg_sel(reg_sel), .alu_op(alu_op), .alu_zero(alu_zero),
    .pc(pc), .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    int                cycles;
  } dexp_t;

  logic [INSTR_W-1:0] imem [64];
  logic [ADDR_W-1:0]  fetch_q [$];
  logic [4:0]         wr_q [$];
  dexp_t              dmem_q [$];
  int idelay = 0, ddelay = 0;
  int vectors = 0, miscompares = 0, fetch_cnt = 0, dreq_cycles = 0;

  function automatic logic [INSTR_W-1:0] enc(logic [3:0] op, logic [1:0] rs, logic [5:0] a);
    return {op, rs, a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexp(string name, logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event, value 0x%0h, nothing expected", name, act);
  endtask

  // Memory responders: ack after a programmable number of wait cycles
  initial begin
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.instr = '0;
    forever begin
      int iw, dw;
      @(posedge clk); #1;
      if (bus.imem_req) begin
        bus.instr = imem[bus.imem_addr];
        if (iw >= idelay) begin bus.imem_ack = 1'b1; iw = 0; end
        else begin bus.imem_ack = 1'b0; iw++; end
      end else begin bus.imem_ack = 1'b0; iw = 0; end
      if (bus.dmem_req) begin
        if (dw >= ddelay) begin bus.dmem_ack = 1'b1; dw = 0; end
        else begin bus.dmem_ack = 1'b0; dw++; end
      end else begin bus.dmem_ack = 1'b0; dw = 0; end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dmem_req) dreq_cycles++;
      if (bus.imem_req && bus.imem_ack) begin
        fetch_cnt++;
        if (fetch_q.size() == 0) unexp("fetch", 32'(bus.imem_addr));
        else chk("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
      end
      if (bus.dmem_req && bus.dmem_ack) begin
        if (dmem_q.size() == 0) unexp("dmem", 32'(bus.dmem_addr));
        else begin
          dexp_t e;
          e = dmem_q.pop_front();
          chk("dmem_addr", 32'(bus.dmem_addr), 32'(e.addr));
          chk("dmem_we", 32'(bus.dmem_we), 32'(e.we));
          chk("dmem_req_cycles", dreq_cycles, e.cycles);
        end
        dreq_cycles = 0;
      end
      if (reg_write) begin
        if (wr_q.size() == 0) unexp("reg_write", {reg_sel, alu_op});
        else chk("reg_write_sel_op", 32'({reg_sel, alu_op}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    #2;
    fetch_q.delete(); wr_q.delete(); dmem_q.delete();
    fetch_cnt = 0; dreq_cycles = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) imem[i] = enc(OP_HALT, 2'd0, 6'd0);
  endtask

  task automatic wait_halt(string name, int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    chk(name, 32'(halted), 32'd1);
  endtask

  task automatic queues_empty(string name);
    chk({name, "_fetch_left"}, fetch_q.size(), 0);
    chk({name, "_wr_left"}, wr_q.size(), 0);
    chk({name, "_dmem_left"}, dmem_q.size(), 0);
  endtask

  initial begin
    int reqs;
    #3;
    chk("rst_imem_req", 32'(bus.imem_req), 0);
    chk("rst_dmem_req_we", 32'({bus.dmem_req, bus.dmem_we}), 0);
    chk("rst_strobes", 32'({reg_write, reg_sel, alu_op}), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flags", 32'({halted, bus_err, illegal}), 0);

    // Run 1: ALU ops, LOAD/STORE with 2 wait cycles, taken JZ, illegal opcode
    fill_halt();
    imem[0]    = enc(OP_ADD,   2'd0, 6'd0);
    imem[1]    = enc(OP_LOAD,  2'd2, 6'd5);
    imem[2]    = enc(OP_STORE, 2'd1, 6'd7);
    imem[3]    = enc(OP_SUB,   2'd0, 6'd0);
    imem[4]    = enc(OP_JZ,    2'd0, 6'h20);
    imem[6'h20] = enc(4'hC,    2'd0, 6'd0);
    imem[6'h21] = enc(OP_AND,  2'd0, 6'd0);
    imem[6'h22] = enc(OP_OR,   2'd0, 6'd0);
    imem[6'h23] = enc(OP_XOR,  2'd0, 6'd0);
    alu_zero = 1'b1; idelay = 0; ddelay = 2;
    do_reset();
    foreach (imem[i]) if (i <= 4 || (i >= 32 && i <= 36)) fetch_q.push_back(6'(i));
    wr_q = '{5'b00_000, 5'b10_000, 5'b00_001, 5'b00_010, 5'b00_011, 5'b00_100};
    dmem_q.push_back('{addr: 6'd5, we: 1'b0, cycles: 3});
    dmem_q.push_back('{addr: 6'd7, we: 1'b1, cycles: 3});
    start_pulse();
    @(negedge clk); chk("c1_imem_req", 32'(bus.imem_req), 1);
    @(negedge clk); chk("c2_decode_quiet", 32'({bus.imem_req, reg_write}), 0);
    @(negedge clk); chk("c3_add_strobe", 32'({reg_write, reg_sel, alu_op}), 32'b1_00_000);
    @(negedge clk); chk("c4_pc", 32'(pc), 1);
    wait_halt("run1_halted", 300);
    chk("run1_pc", 32'(pc), 32'h24);
    chk("run1_illegal", 32'(illegal), 1);
    chk("run1_bus_err", 32'(bus_err), 0);
    queues_empty("run1");
    start_pulse();
    repeat (3) @(negedge clk);
    chk("halt_ignores_start", 32'({halted, bus.imem_req}), 32'b10);

    // Run 2: untaken JZ, JMP to 63, self-jump at 63, then NOP wraps pc
    fill_halt();
    imem[0]  = enc(OP_SUB, 2'd0, 6'd0);
    imem[1]  = enc(OP_JZ,  2'd0, 6'h20);
    imem[2]  = enc(OP_JMP, 2'd0, 6'd63);
    imem[63] = enc(OP_JMP, 2'd0, 6'd63);
    alu_zero = 1'b0; ddelay = 0;
    do_reset();
    fetch_q = '{6'd0, 6'd1, 6'd2, 6'd63, 6'd63, 6'd0};
    wr_q    = '{5'b00_001};
    start_pulse();
    for (int i = 0; i < 100 && fetch_cnt < 4; i++) @(negedge clk);
    chk("run2_reached_63", 32'(fetch_cnt >= 4), 1);
    imem[63] = enc(OP_NOP, 2'd0, 6'd0);
    imem[0]  = enc(OP_HALT, 2'd0, 6'd0);
    wait_halt("run2_halted", 100);
    chk("run2_pc_wrapped", 32'(pc), 0);
    chk("run2_illegal", 32'(illegal), 0);
    queues_empty("run2");

    // Run 3: fetch never acknowledged -> watchdog
    fill_halt();
    idelay = 1000;
    do_reset();
    start_pulse();
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted) break;
      if (bus.imem_req) reqs++;
    end
    chk("wd_req_cycles", reqs, 15);
    chk("wd_halted_err", 32'({halted, bus_err}), 32'b11);
    chk("wd_req_dropped", 32'(bus.imem_req), 0);

    // Run 4: ack in the 15th wait cycle wins over expiry
    idelay = 14;
    do_reset();
    fetch_q.push_back(6'd0);
    start_pulse();
    wait_halt("wd_edge_halted", 60);
    chk("wd_edge_no_err", 32'(bus_err), 0);
    queues_empty("run4");

    // Run 5: asynchronous reset in the middle of a STORE
    fill_halt();
    imem[0] = enc(OP_STORE, 2'd3, 6'd9);
    idelay = 0; ddelay = 1000;
    do_reset();
    fetch_q.push_back(6'd0);
    start_pulse();
    for (int i = 0; i < 10 && !bus.dmem_req; i++) @(negedge clk);
    chk("mem_req_up", 32'({bus.dmem_req, bus.dmem_we, bus.dmem_addr}), 32'b1_1_001001);
    chk("mem_reg_sel", 32'(reg_sel), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dmem", 32'({bus.dmem_req, bus.dmem_we, bus.dmem_addr}), 0);
    chk("arst_misc", 32'({bus.imem_req, reg_write, reg_sel, pc, halted}), 0);
    ddelay = 0;
    @(negedge clk) rst_n = 1'b1;
    queues_empty("run5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
